instr_encoder_loader: RTL and testbench

//  Inverse of the instruction field decode: packs R/I/J field bundles into 32-bit MIPS words
//  and writes them sequentially into RAM through the ram interface signals. Serves as a

---
 rtl/cpu_types_pkg.sv | 35 +++
 rtl/instr_encoder_loader_word_fifo.sv | 46 ++++
 rtl/instr_encoder_loader.sv | 119 +++++++++++
 tb/tb_instr_encoder_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU field types plus the loader format and state enumerations.
// Loader states carry an LD_ prefix so they do not collide with the RAM status names.
package cpu_types_pkg;

  typedef logic [5:0] opcode_t;
  typedef logic [5:0] funct_t;

  typedef struct packed {
    opcode_t    opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    funct_t     funct;
  } r_t;

  typedef struct packed {
    opcode_t     opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } i_t;

  typedef struct packed {
    opcode_t     opcode;
    logic [25:0] addr;
  } j_t;

  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;

  typedef enum logic [1:0] {FMT_R = 2'd0, FMT_I = 2'd1, FMT_J = 2'd2, FMT_BAD = 2'd3} fmt_t;

  typedef enum logic [1:0] {LD_IDLE = 2'd0, LD_RUN = 2'd1, LD_DONE = 2'd2, LD_ERROR = 2'd3} loader_state_t;

endpackage

// File: rtl/instr_encoder_loader_word_fifo.sv
// Synchronous FIFO of {last, word}; flush empties it in one cycle and wins over push/pop.
module word_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // Storage needs no reset: the occupancy count alone defines validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs R/I/J field bundles into MIPS words, queues them, and streams them to RAM
// at consecutive word addresses starting from BASE_ADDR each session.
module instr_encoder_loader
  import cpu_types_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] addr,
  input  logic        last,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [1:0]  ramstate,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] count
);

  loader_state_t state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   count_q, count_d;

  r_t          r_fld;
  i_t          i_fld;
  j_t          j_fld;
  logic [31:0] word;
  logic        full, empty, head_last;
  logic        run, accept, bad, push, wr_ok, wr_err, begin_run;

  assign r_fld = '{opcode: opcode, rs: rs, rt: rt, rd: rd, shamt: shamt, funct: funct};
  assign i_fld = '{opcode: opcode, rs: rs, rt: rt, imm: imm};
  assign j_fld = '{opcode: opcode, addr: addr};

  always_comb begin
    word = r_fld;
    case (fmt_t'(fmt))
      FMT_I:   word = i_fld;
      FMT_J:   word = j_fld;
      default: word = r_fld;
    endcase
  end

  assign run       = (state_q == LD_RUN);
  assign in_ready  = run && !full;
  assign accept    = in_valid && in_ready;
  assign bad       = accept && (fmt_t'(fmt) == FMT_BAD);
  assign push      = accept && !bad;
  assign ramWEN    = run && !empty;
  assign wr_ok     = ramWEN && (ramstate_t'(ramstate) == ACCESS);
  assign wr_err    = ramWEN && (ramstate_t'(ramstate) == ERROR);
  assign begin_run = start && !run;

  word_fifo #(.DEPTH(DEPTH), .W(33)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .flush (begin_run),
    .push  (push),
    .din   ({last, word}),
    .pop   (wr_ok),
    .dout  ({head_last, ramstore}),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    case (state_q)
      LD_RUN: begin
        // An error wins over a same-cycle completion; the pop itself still happens.
        if (wr_err || bad)          state_d = LD_ERROR;
        else if (wr_ok && head_last) state_d = LD_DONE;
      end
      default: if (start) state_d = LD_RUN;
    endcase
    if (begin_run) begin
      addr_d  = BASE_ADDR;
      count_d = '0;
    end else if (wr_ok) begin
      addr_d  = addr_q + 32'd4;
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= LD_IDLE;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  assign ramaddr = addr_q;
  assign count   = count_q;
  assign busy    = run;
  assign done    = (state_q == LD_DONE);
  assign error   = (state_q == LD_ERROR);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encoding table plus stall, error, reset and wrap sequences.
module tb_instr_encoder_loader;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, start, in_valid, last;
  logic [1:0]  fmt, ramstate;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] addr;

  logic        in_ready, ramWEN, busy, done, error;
  logic [31:0] ramaddr, ramstore;
  logic [15:0] count;
  logic        in_ready2, ramWEN2, busy2, done2, error2;
  logic [31:0] ramaddr2, ramstore2;
  logic [15:0] count2;

  instr_encoder_loader #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .addr(addr), .last(last), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramstate(ramstate), .busy(busy), .done(done), .error(error),
    .count(count));

  instr_encoder_loader #(.DEPTH(4), .BASE_ADDR(32'hFFFF_FFFC)) dut2 (
    .CLK(CLK), .RST(RST), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .addr(addr), .last(last), .ramWEN(ramWEN2), .ramaddr(ramaddr2),
    .ramstore(ramstore2), .ramstate(ramstate), .busy(busy2), .done(done2), .error(error2),
    .count(count2));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] ad;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_bundle(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
                            input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                            input logic [5:0] fn, input logic [15:0] im, input logic [25:0] ad,
                            input logic l);
    fmt = f; opcode = op; rs = s; rt = t; rd = d; shamt = sh; funct = fn;
    imm = im; addr = ad; last = l;
  endtask

  // R-type with only funct set encodes to the word value k.
  task automatic set_word(input int k, input logic l);
    set_bundle(2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'(k), 16'hA5A5, 26'h155_5555, l);
  endtask

  task automatic begin_session();
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pushed, nw;
    logic acc;

    vt[0] = '{2'd0, 6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'hBEEF, 26'h2AA_AAAA, 32'h0022_1820};
    vt[1] = '{2'd1, 6'h08, 5'd0,  5'd8,  5'h1F, 5'h1F, 6'h3F, 16'h0005, 26'h155_5555, 32'h2008_0005};
    vt[2] = '{2'd2, 6'h02, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 26'h000_0010, 32'h0800_0010};
    vt[3] = '{2'd0, 6'h00, 5'd0,  5'd9,  5'd10, 5'd4,  6'h00, 16'hFFFF, 26'h3FF_FFFF, 32'h0009_5100};
    vt[4] = '{2'd1, 6'h23, 5'd29, 5'd8,  5'h1F, 5'h1F, 6'h3F, 16'hFFFC, 26'h3FF_FFFF, 32'h8FA8_FFFC};
    vt[5] = '{2'd2, 6'h03, 5'h15, 5'h0A, 5'h15, 5'h0A, 6'h2A, 16'h1234, 26'h3FF_FFFF, 32'h0FFF_FFFF};

    RST = 1'b1; start = 1'b0; in_valid = 1'b0; ramstate = FREE;
    set_word(0, 1'b0);
    repeat (2) @(negedge CLK);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst ramWEN", 32'(ramWEN), 32'd0);
    chk("rst ramaddr", ramaddr, 32'h0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst flags", {29'd0, busy, done, error}, 32'd0);
    chk("rst ramaddr2", ramaddr2, 32'hFFFF_FFFC);
    RST = 1'b0;

    // Encoding table, one word at a time.
    begin_session();
    chk("run busy", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) begin
      set_bundle(vt[i].fmt, vt[i].op, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].sh, vt[i].fn,
                 vt[i].imm, vt[i].ad, i == 5);
      in_valid = 1'b1;
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
      chk($sformatf("vec%0d wen_before", i), 32'(ramWEN), 32'd0);
      @(negedge CLK);
      in_valid = 1'b0;
      chk($sformatf("vec%0d ramWEN", i), 32'(ramWEN), 32'd1);
      chk($sformatf("vec%0d ramstore", i), ramstore, vt[i].exp);
      chk($sformatf("vec%0d ramaddr", i), ramaddr, 32'(4 * i));
      ramstate = ACCESS;
      @(negedge CLK);
      ramstate = FREE;
      chk($sformatf("vec%0d count", i), 32'(count), 32'(i + 1));
    end
    chk("table done", 32'(done), 32'd1);
    chk("table busy", 32'(busy), 32'd0);
    chk("table in_ready", 32'(in_ready), 32'd0);
    chk("table ramWEN", 32'(ramWEN), 32'd0);

    // RAM stall with a full FIFO, then drain.
    begin_session();
    ramstate = BUSY;
    pushed = 0;
    set_word(1, 1'b0);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      acc = in_valid && in_ready;
      @(negedge CLK);
      if (acc) pushed++;
      chk($sformatf("stall%0d ramWEN", c), 32'(ramWEN), 32'(pushed > 0));
      if (pushed > 0) begin
        chk($sformatf("stall%0d ramstore", c), ramstore, 32'd1);
        chk($sformatf("stall%0d ramaddr", c), ramaddr, 32'd0);
      end
      set_word(pushed + 1, pushed + 1 == 5);
      in_valid = (pushed < 5);
    end
    chk("stall pushed", 32'(pushed), 32'd4);
    chk("stall in_ready", 32'(in_ready), 32'd0);
    chk("stall count", 32'(count), 32'd0);
    ramstate = ACCESS;
    nw = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      if (ramWEN) begin
        chk($sformatf("drain%0d ramstore", nw), ramstore, 32'(nw + 1));
        chk($sformatf("drain%0d ramaddr", nw), ramaddr, 32'(4 * nw));
        nw++;
      end
      acc = in_valid && in_ready;
      @(negedge CLK);
      if (acc) pushed++;
      set_word(pushed + 1, pushed + 1 == 5);
      in_valid = (pushed < 5);
    end
    ramstate = FREE;
    in_valid = 1'b0;
    chk("drain words", 32'(nw), 32'd5);
    chk("drain done", 32'(done), 32'd1);
    chk("drain count", 32'(count), 32'd5);

    // RAM error on the second write.
    begin_session();
    set_word(7, 1'b0);
    in_valid = 1'b1;
    @(negedge CLK);
    set_word(8, 1'b0);
    ramstate = ACCESS;
    @(negedge CLK);
    in_valid = 1'b0;
    chk("err2 ramWEN", 32'(ramWEN), 32'd1);
    chk("err2 ramstore", ramstore, 32'd8);
    chk("err2 ramaddr", ramaddr, 32'd4);
    ramstate = ERROR;
    @(negedge CLK);
    ramstate = FREE;
    chk("err error", 32'(error), 32'd1);
    chk("err count", 32'(count), 32'd1);
    chk("err ramWEN", 32'(ramWEN), 32'd0);
    chk("err busy", 32'(busy), 32'd0);
    begin_session();
    chk("restart busy", 32'(busy), 32'd1);
    chk("restart count", 32'(count), 32'd0);
    chk("restart ramaddr", ramaddr, 32'd0);
    chk("restart ramWEN", 32'(ramWEN), 32'd0);
    chk("restart error", 32'(error), 32'd0);

    // Illegal format alone.
    set_bundle(2'd3, 6'h3F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 26'h3FF_FFFF, 1'b0);
    in_valid = 1'b1;
    chk("bad in_ready", 32'(in_ready), 32'd1);
    @(negedge CLK);
    in_valid = 1'b0;
    chk("bad error", 32'(error), 32'd1);
    chk("bad ramWEN", 32'(ramWEN), 32'd0);
    chk("bad count", 32'(count), 32'd0);

    // Illegal format in the same cycle as a completed write.
    begin_session();
    set_word(9, 1'b0);
    in_valid = 1'b1;
    @(negedge CLK);
    set_bundle(2'd3, 6'h3F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 26'h3FF_FFFF, 1'b0);
    ramstate = ACCESS;
    @(negedge CLK);
    in_valid = 1'b0;
    ramstate = FREE;
    chk("badacc count", 32'(count), 32'd1);
    chk("badacc error", 32'(error), 32'd1);
    chk("badacc ramaddr", ramaddr, 32'd4);

    // Reset during a pending write.
    begin_session();
    set_word(10, 1'b0);
    in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    chk("rstmid ramWEN_pre", 32'(ramWEN), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    chk("rstmid ramWEN", 32'(ramWEN), 32'd0);
    chk("rstmid ramaddr", ramaddr, 32'd0);
    chk("rstmid count", 32'(count), 32'd0);
    chk("rstmid in_ready", 32'(in_ready), 32'd0);
    chk("rstmid flags", {29'd0, busy, done, error}, 32'd0);
    RST = 1'b0;

    // Address wrap on the instance based at the top word of memory.
    begin_session();
    set_word(11, 1'b0);
    in_valid = 1'b1;
    @(negedge CLK);
    chk("wrap0 ramWEN", 32'(ramWEN2), 32'd1);
    chk("wrap0 ramaddr", ramaddr2, 32'hFFFF_FFFC);
    chk("wrap0 ramstore", ramstore2, 32'd11);
    set_word(12, 1'b1);
    ramstate = ACCESS;
    @(negedge CLK);
    in_valid = 1'b0;
    ramstate = FREE;
    chk("wrap1 ramWEN", 32'(ramWEN2), 32'd1);
    chk("wrap1 ramaddr", ramaddr2, 32'h0000_0000);
    chk("wrap1 ramstore", ramstore2, 32'd12);
    ramstate = ACCESS;
    @(negedge CLK);
    ramstate = FREE;
    chk("wrap done", 32'(done2), 32'd1);
    chk("wrap count", 32'(count2), 32'd2);
    chk("wrap ramaddr", ramaddr2, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
